// File: rtl/packet_rr_arbiter_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
//   arb_state_e   : arbiter state, idle (no packet open) or busy (locked to one owner)
//   MaxReq        : widest request vector the grant helper accepts
//   rr_next_grant : first requester found searching upward from ptr+1, wrapping mod n_req
package packet_rr_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  localparam int unsigned MaxReq = 32;

  // Returns ptr when nothing requests; callers qualify the result with |req.
  function automatic int unsigned rr_next_grant(input logic [MaxReq-1:0] req,
                                                input int unsigned       ptr,
                                                input int unsigned       n_req);
    int unsigned idx;
    logic        found;
    rr_next_grant = ptr;
    found         = 1'b0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      idx = (ptr + k) % n_req;
      if (!found && (k <= n_req) && req[idx]) begin
        rr_next_grant = idx;
        found         = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational rotating priority encoder. The request just above ptr_i has top
// priority; the search wraps, so ptr_i itself has the lowest priority.
//   req_i : request vector
//   ptr_i : index of the most recently granted requester
//   sel_o : selected index (equals ptr_i when nothing requests)
//   any_o : at least one request is active
module rr_priority_select
  import packet_rr_arbiter_pkg::*;
#(
  parameter int unsigned NReq = 4
) (
  input  logic [NReq-1:0]         req_i,
  input  logic [$clog2(NReq)-1:0] ptr_i,
  output logic [$clog2(NReq)-1:0] sel_o,
  output logic                    any_o
);

  localparam int unsigned IdxW = $clog2(NReq);

  logic [MaxReq-1:0] req_ext;

  always_comb begin
    req_ext            = '0;
    req_ext[NReq-1:0]  = req_i;
    sel_o              = IdxW'(rr_next_grant(req_ext, 32'(ptr_i), NReq));
    any_o              = |req_i;
  end

endmodule

// File: rtl/packet_rr_arbiter.sv
// Merges NReq valid/last packet streams onto one downstream channel. Arbitration is
// round-robin per packet: the winner keeps the channel until its last beat is accepted.
// The grant is zero-latency; all datapath outputs are combinational from the inputs.
// Optional stall watchdog: define PACKET_RR_ARBITER_WATCHDOG_EN.
//   clock_i, reset_i           : clock, synchronous active-high reset
//   req_valid_i/last_i/data_i  : upstream beats, requester i at data bits [i*Width +: Width]
//   req_ready_o                : beat of requester i accepted this cycle
//   down_valid/first/last/data : merged stream (first/last/data are 0 when not valid)
//   down_grant_o               : requester driving the beat; holds its value when idle
//   down_ready_i               : downstream accepts the beat
//   watchdog_err_o             : one-cycle pulse when a stalled packet is abandoned
module packet_rr_arbiter
  import packet_rr_arbiter_pkg::*;
#(
  parameter int unsigned Width     = 8,
  parameter int unsigned NReq      = 4,
  parameter int unsigned IdleLimit = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [NReq-1:0]         req_valid_i,
  input  logic [NReq-1:0]         req_last_i,
  input  logic [NReq*Width-1:0]   req_data_i,
  output logic [NReq-1:0]         req_ready_o,
  output logic                    down_valid_o,
  output logic                    down_first_o,
  output logic                    down_last_o,
  output logic [Width-1:0]        down_data_o,
  output logic [$clog2(NReq)-1:0] down_grant_o,
  input  logic                    down_ready_i,
  output logic                    watchdog_err_o
);

  localparam int unsigned IdxW = $clog2(NReq);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;

  logic [IdxW-1:0]  sel;
  logic             any_req;
  logic [IdxW-1:0]  cur_idx;
  logic             beat_valid;
  logic             beat_last;
  logic [Width-1:0] beat_data;
  logic             beat_out;
  logic             accept;
  logic             wd_fire;

  rr_priority_select #(
    .NReq (NReq)
  ) u_select (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .sel_o (sel),
    .any_o (any_req)
  );

  // Source selection: the locked owner while busy, the fresh round-robin pick while idle.
  always_comb begin
    cur_idx    = (state_q == StBusy) ? owner_q : sel;
    beat_valid = (state_q == StBusy) ? req_valid_i[owner_q] : any_req;
    beat_last  = req_last_i[cur_idx];
    beat_data  = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      if (cur_idx == IdxW'(i)) begin
        beat_data = req_data_i[i*Width +: Width];
      end
    end
  end

  assign beat_out = beat_valid & ~reset_i;
  assign accept   = beat_out & down_ready_i;

`ifdef PACKET_RR_ARBITER_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(IdleLimit + 1);

  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

  // Fires on the IdleLimit-th consecutive cycle the owner is not valid.
  assign wd_fire = (state_q == StBusy) & ~req_valid_i[owner_q] &
                   (idle_cnt_q == CntW'(IdleLimit - 1));

  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == StBusy) && !req_valid_i[owner_q] && !wd_fire) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_idle_limit;
  assign unused_idle_limit = ^IdleLimit;
  assign wd_fire           = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= IdxW'(NReq - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Next state. ptr already equals owner while busy, so a watchdog abort leaves the
  // stalled requester at the lowest priority without touching ptr.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = beat_out ? cur_idx : grant_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ptr_d = sel;
          if (!beat_last) begin
            state_d = StBusy;
            owner_d = sel;
          end
        end
      end
      StBusy: begin
        if (wd_fire) begin
          state_d = StIdle;
        end else if (accept && beat_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    down_valid_o   = beat_out;
    down_first_o   = beat_out & (state_q == StIdle);
    down_last_o    = beat_out & beat_last;
    down_data_o    = beat_out ? beat_data : '0;
    down_grant_o   = reset_i ? '0 : (beat_out ? cur_idx : grant_q);
    req_ready_o    = '0;
    if (accept) begin
      req_ready_o[cur_idx] = 1'b1;
    end
    watchdog_err_o = wd_fire & ~reset_i;
  end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Bench for packet_rr_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a packet-level round-robin reference model.
module tb_packet_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IL = 16;
  localparam int GW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic           down_valid, down_first, down_last, down_ready, wd_err;
  logic [W-1:0]   down_data;
  logic [GW-1:0]  down_grant;

  always #5 clk = ~clk;

  packet_rr_arbiter #(
    .Width     (W),
    .NReq      (N),
    .IdleLimit (IL)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .req_valid_i    (req_valid),
    .req_last_i     (req_last),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .down_valid_o   (down_valid),
    .down_first_o   (down_first),
    .down_last_o    (down_last),
    .down_data_o    (down_data),
    .down_grant_o   (down_grant),
    .down_ready_i   (down_ready),
    .watchdog_err_o (wd_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Upstream sources: a queue of packet lengths per requester.
  int         pkt_len[N][$];
  int         beat[N];
  logic [W-1:0] cur_data[N];
  bit         held[N];
  bit         mute[N];
  bit         rand_gap, rand_ready;
  logic       ready_val;

  // Reference model state.
  bit m_open;
  int m_owner, m_ptr, m_last_grant, m_idle;

  // Observed accepted beats.
  int acc_grant[$];
  int acc_first[$];
  int exp_g[$];
  int exp_f[$];
  bit obs_err;

  task automatic model_reset();
    m_open       = 1'b0;
    m_owner      = 0;
    m_ptr        = N - 1;
    m_last_grant = 0;
    m_idle       = 0;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += pkt_len[i].size();
    return s;
  endfunction

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin
      pkt_len[i].delete();
      beat[i] = 0;
      held[i] = 1'b0;
      mute[i] = 1'b0;
    end
  endtask

  task automatic step_cycle();
    int idx, j;
    bit ev, el, ex_err, has;
    logic [W-1:0] ed;
    logic [N-1:0] er, rdy_obs;
    for (int i = 0; i < N; i++) begin
      has          = pkt_len[i].size() > 0;
      req_valid[i] = has && !mute[i] && (held[i] || !rand_gap || $urandom_range(3) != 0);
      req_last[i]  = has && (beat[i] == pkt_len[i][0] - 1);
      req_data[i*W +: W] = cur_data[i];
    end
    down_ready = rand_ready ? ($urandom_range(3) != 0) : ready_val;
    #1;
    idx = -1;
    if (m_open) idx = m_owner;
    else begin
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr + k) % N;
        if (idx < 0 && req_valid[j]) idx = j;
      end
    end
    ev     = !rst && idx >= 0 && req_valid[idx];
    ex_err = 1'b0;
`ifdef PACKET_RR_ARBITER_WATCHDOG_EN
    ex_err = !rst && m_open && !req_valid[m_owner] && (m_idle + 1 == IL);
`endif
    el = ev && req_last[idx];
    ed = ev ? cur_data[idx] : '0;
    er = '0;
    if (ev && down_ready) er[idx] = 1'b1;
    check_eq("valid", 32'(down_valid), 32'(ev));
    check_eq("first", 32'(down_first), 32'(ev && !m_open));
    check_eq("last", 32'(down_last), 32'(el));
    check_eq("data", 32'(down_data), 32'(ed));
    check_eq("grant", 32'(down_grant), rst ? 32'd0 : (ev ? 32'(idx) : 32'(m_last_grant)));
    check_eq("ready", 32'(req_ready), 32'(er));
    check_eq("wd_err", 32'(wd_err), 32'(ex_err));
    rdy_obs = req_ready;
    obs_err = wd_err;
    if (down_valid && down_ready) begin
      acc_grant.push_back(int'(down_grant));
      acc_first.push_back(int'(down_first));
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (ev) m_last_grant = idx;
      if (m_open) begin
        if (ex_err) begin
          m_open = 1'b0;
          m_idle = 0;
        end else if (req_valid[m_owner]) m_idle = 0;
        else m_idle++;
        if (ev && down_ready && el) m_open = 1'b0;
      end else if (ev && down_ready) begin
        m_ptr = idx;
        if (!el) begin
          m_open  = 1'b1;
          m_owner = idx;
          m_idle  = 0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      held[i] = req_valid[i] && !rdy_obs[i];
      if (req_valid[i] && rdy_obs[i]) begin
        if (req_last[i]) begin
          void'(pkt_len[i].pop_front());
          beat[i] = 0;
        end else beat[i]++;
        cur_data[i] = W'($urandom);
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int max_cycles);
    int c = 0;
    while (pending() > 0 && c < max_cycles) begin
      step_cycle();
      c++;
    end
    check_eq(tag, 32'(pending()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int c = 0; c < cycles; c++) step_cycle();
    rst = 1'b0;
    clear_srcs();
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_n"}, 32'(acc_grant.size()), 32'(exp_g.size()));
    for (int k = 0; k < exp_g.size(); k++) begin
      check_eq($sformatf("%s_g%0d", tag, k),
               (k < acc_grant.size()) ? 32'(acc_grant[k]) : 32'hffff_ffff, 32'(exp_g[k]));
      check_eq($sformatf("%s_f%0d", tag, k),
               (k < acc_first.size()) ? 32'(acc_first[k]) : 32'hffff_ffff, 32'(exp_f[k]));
    end
    acc_grant.delete();
    acc_first.delete();
  endtask

  initial begin
    int fire_at;
    rst        = 1'b1;
    ready_val  = 1'b1;
    rand_gap   = 1'b0;
    rand_ready = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    down_ready = 1'b0;
    model_reset();
    clear_srcs();
    for (int i = 0; i < N; i++) cur_data[i] = W'($urandom);
    @(negedge clk);

    // Reset with traffic present: outputs stay 0.
    for (int i = 0; i < N; i++) pkt_len[i].push_back(2);
    do_reset(3);
    acc_grant.delete();
    acc_first.delete();

    // Single-beat packets from req0 and req2 alternate.
    pkt_len[0] = '{1, 1};
    pkt_len[2] = '{1, 1};
    run("t2_drain", 20);
    exp_g = '{0, 2, 0, 2};
    exp_f = '{1, 1, 1, 1};
    check_log("t2");

    // req1 three-beat packet holds off req0; req0 wins right after.
    pkt_len[0] = '{1};
    run("t3a_drain", 5);
    acc_grant.delete();
    acc_first.delete();
    pkt_len[1] = '{3};
    pkt_len[0] = '{1};
    run("t3_drain", 20);
    exp_g = '{1, 1, 1, 0};
    exp_f = '{1, 0, 0, 1};
    check_log("t3");

    // Downstream stall mid-packet.
    pkt_len[3] = '{4};
    step_cycle();
    ready_val = 1'b0;
    for (int c = 0; c < 4; c++) step_cycle();
    check_eq("stall_beat", 32'(beat[3]), 32'd1);
    ready_val = 1'b1;
    run("t4_drain", 10);
    acc_grant.delete();
    acc_first.delete();

    // All four requesters with 2-beat packets: pointer wrap.
    do_reset(1);
    for (int i = 0; i < N; i++) pkt_len[i] = '{2, 2};
    run("t5_drain", 40);
    exp_g = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    exp_f = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    for (int k = 10; k < 16; k++) begin
      acc_grant.pop_back();
      acc_first.pop_back();
    end
    check_log("t5");

    // Reset during beat 2 of a 4-beat packet.
    do_reset(1);
    pkt_len[2] = '{4};
    step_cycle();
    do_reset(1);
    acc_grant.delete();
    acc_first.delete();
    pkt_len[0] = '{1};
    pkt_len[2] = '{1};
    run("t6_drain", 10);
    exp_g = '{0, 2};
    exp_f = '{1, 1};
    check_log("t6");

    // Randomized traffic with gaps, backpressure and occasional resets.
    rand_gap   = 1'b1;
    rand_ready = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(N - 1);
      if ($urandom_range(2) == 0 && pkt_len[r].size() < 3) pkt_len[r].push_back($urandom_range(4, 1));
      rst = ($urandom_range(299) == 0);
      step_cycle();
    end
    rst = 1'b0;
    run("t7_drain", 2000);
    rand_gap   = 1'b0;
    rand_ready = 1'b0;
    acc_grant.delete();
    acc_first.delete();

`ifdef PACKET_RR_ARBITER_WATCHDOG_EN
    // Owner req3 stalls after beat 1; watchdog frees the channel for req1.
    do_reset(1);
    pkt_len[3] = '{3};
    step_cycle();
    mute[3]    = 1'b1;
    pkt_len[1] = '{1};
    fire_at    = -1;
    for (int k = 1; k <= 40; k++) begin
      step_cycle();
      if (obs_err) begin
        fire_at = k;
        break;
      end
    end
    check_eq("wd_cycle", 32'(fire_at), 32'(IL));
    acc_grant.delete();
    acc_first.delete();
    step_cycle();
    exp_g = '{1};
    exp_f = '{1};
    check_log("wd_next");
    clear_srcs();
`else
    fire_at = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
